// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Build option: define DIV_SAT_EN for saturating results (default wraps).
package div_pkg;

   localparam int DIV_WIDTH   = 16;
   localparam int DIV_LATENCY = DIV_WIDTH + 1;
   localparam int DIV_CNT_W   = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } div_state_t;

   localparam logic [DIV_WIDTH-1:0] Q_POS_SAT = 16'h7FFF;
   localparam logic [DIV_WIDTH-1:0] Q_NEG_SAT = 16'h8000;
   localparam logic [DIV_WIDTH-1:0] Q_DZ_WRAP = 16'hFFFF;

   // Two's complement negation at the datapath width.
   function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] v);
      return (~v) + DIV_WIDTH'(1);
   endfunction

   // Unsigned magnitude; -32768 maps to 0x8000, which is correct read as unsigned.
   function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
      return v[DIV_WIDTH-1] ? negate(v) : v;
   endfunction

endpackage

// File: rtl/div_substep.sv
// One restoring-division iteration: shift, trial subtract, keep or restore.
module div_substep
   import div_pkg::*;
(
   input  logic [DIV_WIDTH:0]   rem,
   input  logic [DIV_WIDTH-1:0] sreg,
   input  logic [DIV_WIDTH-1:0] dmag,
   output logic [DIV_WIDTH:0]   rem_next,
   output logic [DIV_WIDTH-1:0] sreg_next
);

   logic [DIV_WIDTH:0] shifted;
   logic [DIV_WIDTH:0] diff;
   logic               unused_rem_top;

   // The partial remainder always stays below the divisor magnitude, so its top bit
   // is zero on entry and is dropped by the shift.
   assign unused_rem_top = rem[DIV_WIDTH];

   // Trial subtraction; a clear sign bit means the divisor fits and the quotient bit is 1.
   always_comb begin
      shifted   = {rem[DIV_WIDTH-1:0], sreg[DIV_WIDTH-1]};
      diff      = shifted - {1'b0, dmag};
      rem_next  = shifted;
      sreg_next = {sreg[DIV_WIDTH-2:0], 1'b0};
      if (!diff[DIV_WIDTH]) begin
         rem_next  = diff;
         sreg_next = {sreg[DIV_WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider with truncating quotient and fixed WIDTH+1 latency.
// Build option: DIV_SAT_EN selects saturating divide-by-zero / overflow results.
module seq_signed_divider
   import div_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] dividend,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [DIV_WIDTH-1:0] quotient,
   output logic [DIV_WIDTH-1:0] remainder,
   output logic                 dz
);

   localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_WIDTH - 1);

   div_state_t           state, state_next;
   logic [DIV_WIDTH:0]   rem, rem_next;
   logic [DIV_WIDTH-1:0] sreg, sreg_next;
   logic [DIV_WIDTH-1:0] dmag;
   logic [DIV_CNT_W-1:0] cnt;
   logic                 neg_q, neg_r, dz_flag;
   logic [DIV_WIDTH-1:0] q_fix, r_fix;

   div_substep u_substep (
      .rem       (rem),
      .sreg      (sreg),
      .dmag      (dmag),
      .rem_next  (rem_next),
      .sreg_next (sreg_next)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic; busy covers every non-idle cycle.
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (cnt == CNT_LAST) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture on an accepted start, then one iteration per CALC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem     <= '0;
         sreg    <= '0;
         dmag    <= '0;
         cnt     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               rem     <= '0;
               sreg    <= abs_val(dividend);
               dmag    <= abs_val(divisor);
               cnt     <= '0;
               neg_r   <= dividend[DIV_WIDTH-1];
               neg_q   <= dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1];
               dz_flag <= (divisor == '0);
            end
            CALC: begin
               rem  <= rem_next;
               sreg <= sreg_next;
               cnt  <= cnt + DIV_CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Sign fix and special cases. With a zero divisor every trial subtract succeeds,
   // so the partial remainder ends holding |dividend| and the signed remainder
   // naturally equals the original dividend.
   always_comb begin
      r_fix = neg_r ? negate(rem[DIV_WIDTH-1:0]) : rem[DIV_WIDTH-1:0];
      q_fix = neg_q ? negate(sreg) : sreg;
`ifdef DIV_SAT_EN
      if (dz_flag)
         q_fix = neg_r ? Q_NEG_SAT : Q_POS_SAT;
      else if (!neg_q && sreg[DIV_WIDTH-1])
         q_fix = Q_POS_SAT;
`else
      if (dz_flag)
         q_fix = Q_DZ_WRAP;
`endif
   end

   // Result registers, updated only when a division completes; done is a one-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dz        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == FIX) begin
            done      <= 1'b1;
            quotient  <= q_fix;
            remainder <= r_fix;
            dz        <= dz_flag;
         end
      end
   end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider against an integer-arithmetic model.
// Honours DIV_SAT_EN the same way as the design build.
module tb_seq_signed_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dividend, divisor;
   logic        busy, done, dz;
   logic [15:0] quotient, remainder;

   int checks = 0;
   int errors = 0;

   seq_signed_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dz        (dz)
   );

   always #5 clk = ~clk;

   // Reference: C-style truncating division on plain integers.
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic dzr);
      logic signed [15:0] sa, sb;
      int ai, bi, qi, ri;
      sa = a;
      sb = b;
      ai = sa;
      bi = sb;
      if (bi == 0) begin
`ifdef DIV_SAT_EN
         q = (ai >= 0) ? 16'h7FFF : 16'h8000;
`else
         q = 16'hFFFF;
`endif
         r   = a;
         dzr = 1'b1;
      end else begin
         qi = ai / bi;
         ri = ai % bi;
`ifdef DIV_SAT_EN
         if (qi > 32767) qi = 32767;
`endif
         q   = qi[15:0];
         r   = ri[15:0];
         dzr = 1'b0;
      end
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one request; returns just after the edge that sampled start.
   task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Step cycles until done or the bound expires; cyc counts edges since the start edge.
   task automatic wait_done(input int already, output int cyc);
      cyc = already;
      while (!done && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Full transaction with latency, result and single-pulse checks.
   task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] eq, er;
      logic        edz;
      int          cyc;
      ref_div(a, b, eq, er, edz);
      apply_stimulus(a, b);
      check_output({tag, " busy"}, 32'(busy), 32'd1);
      wait_done(0, cyc);
      check_output({tag, " latency"}, cyc, 17);
      check_output({tag, " quotient"}, 32'(quotient), 32'(eq));
      check_output({tag, " remainder"}, 32'(remainder), 32'(er));
      check_output({tag, " dz"}, 32'(dz), 32'(edz));
      check_output({tag, " busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check_output({tag, " done_pulse"}, 32'(done), 32'd0);
      check_output({tag, " quotient_held"}, 32'(quotient), 32'(eq));
   endtask

   initial begin
      int          cyc;
      logic [15:0] ra, rb;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset busy", 32'(busy), 32'd0);
      check_output("reset done", 32'(done), 32'd0);
      check_output("reset quotient", 32'(quotient), 32'd0);
      check_output("reset remainder", 32'(remainder), 32'd0);
      check_output("reset dz", 32'(dz), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_div("100/7", 16'd100, 16'd7);
      run_div("-100/7", -16'sd100, 16'd7);
      run_div("100/-7", 16'd100, -16'sd7);
      run_div("-100/-7", -16'sd100, -16'sd7);
      run_div("min/-1", 16'h8000, 16'hFFFF);
      run_div("min/1", 16'h8000, 16'd1);
      run_div("1234/0", 16'd1234, 16'd0);
      run_div("-5/0", -16'sd5, 16'd0);
      run_div("min/0", 16'h8000, 16'd0);
      run_div("7/min", 16'd7, 16'h8000);
      run_div("max/max", 16'h7FFF, 16'h7FFF);

      // Second start while busy must be ignored.
      apply_stimulus(16'd9, 16'd2);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start    = 1'b1;
      dividend = 16'd50;
      divisor  = 16'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_output("busy_ign busy", 32'(busy), 32'd1);
      wait_done(5, cyc);
      check_output("busy_ign latency", cyc, 17);
      check_output("busy_ign quotient", 32'(quotient), 32'd4);
      check_output("busy_ign remainder", 32'(remainder), 32'd1);
      cyc = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) cyc++;
      end
      check_output("busy_ign extra_done", cyc, 0);

      // Reset in the middle of an operation aborts it.
      apply_stimulus(16'd30000, 16'd3);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("abort busy", 32'(busy), 32'd0);
      check_output("abort quotient", 32'(quotient), 32'd0);
      check_output("abort remainder", 32'(remainder), 32'd0);
      check_output("abort dz", 32'(dz), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done || busy) cyc++;
      end
      check_output("abort no_done", cyc, 0);
      run_div("30000/3", 16'd30000, 16'd3);

      // Randomised operands, including occasional zero and small divisors.
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 5))
            0:       rb = 16'd0;
            1:       rb = 16'($urandom_range(1, 9));
            2:       rb = -16'($urandom_range(1, 9));
            default: rb = 16'($urandom);
         endcase
         run_div($sformatf("rand%0d", i), ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
